// File: rtl/irda_fir_tx_frame_ctrl_if.sv
// irda_fir_tx_frame_ctrl_if
// This interface bundles the strobe, control and chip-stream signals of the
// IrDA FIR transmit frame controller.
//
// Signals:
//   fir_tx8_enable  8 Mchip/s chip strobe (one clk wide)
//   fir_tx4_enable  4 Mbit/s bit strobe, coincides with every second chip strobe
//   tx_go           one-cycle frame start request
//   tx_abort        one-cycle abort request
//   data_last       high while the serializer presents the final data bit
//   ppm_i           chip from the 4PPM encoder
//   ppm_restart     one-cycle restart pulse to the 4PPM encoder
//   next_data_fir   bit-advance strobe to the serializer and encoder
//   fir_tx_o        registered chip stream to the LED driver
//   tx_busy         high whenever a frame is in progress
//   tx_done         one-cycle pulse on normal frame completion
//   tx_err          sticky odd-bit-count error
//
// Modports: master drives the requests and strobes (system side), slave is
// the frame controller.
interface irda_fir_tx_frame_ctrl_if;
  logic fir_tx8_enable;
  logic fir_tx4_enable;
  logic tx_go;
  logic tx_abort;
  logic data_last;
  logic ppm_i;
  logic ppm_restart;
  logic next_data_fir;
  logic fir_tx_o;
  logic tx_busy;
  logic tx_done;
  logic tx_err;

  modport master (
    output fir_tx8_enable, fir_tx4_enable, tx_go, tx_abort, data_last, ppm_i,
    input  ppm_restart, next_data_fir, fir_tx_o, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  fir_tx8_enable, fir_tx4_enable, tx_go, tx_abort, data_last, ppm_i,
    output ppm_restart, next_data_fir, fir_tx_o, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/irda_fir_tx_frame_ctrl.sv
// irda_fir_tx_frame_ctrl
// This module sequences one IrDA FIR (4 Mbit/s, 4PPM) transmit frame. A frame is
// built from PREAMBLE_REPS preamble symbols, a start flag, the 4PPM data chips,
// DRAIN_CHIPS trailing encoder chips and a stop flag. All chip output changes
// happen on fir_tx8_enable, except an abort, which forces the line low at once.
//
// Parameters:
//   PREAMBLE_REPS  number of 16-chip preamble symbols (1..31)
//   DRAIN_CHIPS    chips passed through after the last data bit (1..31)
//
// Ports:
//   clk       system clock, rising edge
//   wb_rst_i  asynchronous active-high reset
//   bus       irda_fir_tx_frame_ctrl_if.slave (strobes, requests, chip stream,
//             status)
module irda_fir_tx_frame_ctrl #(
  parameter int PREAMBLE_REPS = 16,
  parameter int DRAIN_CHIPS   = 8
) (
  input logic                     clk,
  input logic                     wb_rst_i,
  irda_fir_tx_frame_ctrl_if.slave bus
);

  localparam logic [15:0] PREAMBLE_PAT = 16'h80A8;
  localparam logic [31:0] START_PAT    = 32'h0C0C_6060;
  localparam logic [31:0] STOP_PAT     = 32'h0C0C_0606;
  localparam logic [4:0]  REP_LAST     = 5'(PREAMBLE_REPS - 1);
  localparam logic [4:0]  DRAIN_LAST   = 5'(DRAIN_CHIPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    DRAIN,
    STOP
  } state_t;

  state_t     state;
  logic [4:0] chip_cnt;
  logic [4:0] rep_cnt;
  logic       bit_odd;
  logic       fir_tx;
  logic       ppm_restart;
  logic       tx_done;
  logic       tx_err;
  logic       next_data;
  logic [3:0] pre_idx;
  logic [4:0] flag_idx;

  // Patterns are sent MSB first, so the chip counter indexes from the top.
  assign pre_idx  = 4'd15 - chip_cnt[3:0];
  assign flag_idx = 5'd31 - chip_cnt;

  // The bit advance must reach the serializer in the same cycle as the bit
  // strobe, so it is not registered.
  assign next_data = bus.fir_tx4_enable && (state == DATA);

  assign bus.next_data_fir = next_data;
  assign bus.fir_tx_o      = fir_tx;
  assign bus.ppm_restart   = ppm_restart;
  assign bus.tx_done       = tx_done;
  assign bus.tx_err        = tx_err;
  assign bus.tx_busy       = (state != IDLE);

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      chip_cnt    <= 5'd0;
      rep_cnt     <= 5'd0;
      bit_odd     <= 1'b0;
      fir_tx      <= 1'b0;
      ppm_restart <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      ppm_restart <= 1'b0;
      tx_done     <= 1'b0;
      // Abort overrides everything, including a simultaneous tx_go, and does
      // not wait for a chip strobe to silence the line.
      if (state != IDLE && bus.tx_abort) begin
        state       <= IDLE;
        chip_cnt    <= 5'd0;
        rep_cnt     <= 5'd0;
        fir_tx      <= 1'b0;
        ppm_restart <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.fir_tx8_enable) fir_tx <= 1'b0;
            if (bus.tx_go && !bus.tx_abort) begin
              state       <= PREAMBLE;
              chip_cnt    <= 5'd0;
              rep_cnt     <= 5'd0;
              bit_odd     <= 1'b0;
              tx_err      <= 1'b0;
              ppm_restart <= 1'b1;
            end
          end
          PREAMBLE: begin
            if (bus.fir_tx8_enable) begin
              fir_tx <= PREAMBLE_PAT[pre_idx];
              if (chip_cnt == 5'd15) begin
                chip_cnt <= 5'd0;
                if (rep_cnt == REP_LAST) begin
                  rep_cnt <= 5'd0;
                  state   <= START;
                end else begin
                  rep_cnt <= rep_cnt + 5'd1;
                end
              end else begin
                chip_cnt <= chip_cnt + 5'd1;
              end
            end
          end
          START: begin
            if (bus.fir_tx8_enable) begin
              fir_tx <= START_PAT[flag_idx];
              if (chip_cnt == 5'd31) begin
                chip_cnt <= 5'd0;
                state    <= DATA;
              end else begin
                chip_cnt <= chip_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            if (bus.fir_tx8_enable) fir_tx <= bus.ppm_i;
            // bit_odd low here means the bit being taken is the 1st, 3rd, ...
            if (next_data) begin
              bit_odd <= ~bit_odd;
              if (bus.data_last) begin
                state    <= DRAIN;
                chip_cnt <= 5'd0;
                if (!bit_odd) tx_err <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (bus.fir_tx8_enable) begin
              fir_tx <= bus.ppm_i;
              if (chip_cnt == DRAIN_LAST) begin
                chip_cnt <= 5'd0;
                state    <= STOP;
              end else begin
                chip_cnt <= chip_cnt + 5'd1;
              end
            end
          end
          STOP: begin
            if (bus.fir_tx8_enable) begin
              fir_tx <= STOP_PAT[flag_idx];
              if (chip_cnt == 5'd31) begin
                chip_cnt <= 5'd0;
                state    <= IDLE;
                tx_done  <= 1'b1;
              end else begin
                chip_cnt <= chip_cnt + 5'd1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            chip_cnt <= 5'd0;
            rep_cnt  <= 5'd0;
            fir_tx   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/irda_fir_tx_frame_ctrl.md
IRDA_FIR_TX_FRAME_CTRL -- requirements
Module: irda_fir_tx_frame_ctrl

Interface
REQ-001 Parameter PREAMBLE_REPS, default 16, number of 16-chip preamble symbols per frame (legal 1..31).
REQ-002 Parameter DRAIN_CHIPS, default 8, chip strobes waited after last data bit before the stop flag (legal 1..31).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 fir_tx8_enable  input  1  8 Mchip/s chip strobe, one clk wide.
REQ-006 fir_tx4_enable  input  1  4 Mbit/s bit strobe; asserts only together with every second fir_tx8_enable.
REQ-007 tx_go  input  1  one-cycle frame start request.
REQ-008 tx_abort  input  1  one-cycle abort request.
REQ-009 data_last  input  1  level from upstream serializer; high while the final data bit is presented.
REQ-010 ppm_i  input  1  chip output of the 4PPM encoder.
REQ-011 ppm_restart  output  1  one-cycle restart pulse to the 4PPM encoder.
REQ-012 next_data_fir  output  1  bit-advance strobe to serializer and encoder.
REQ-013 fir_tx_o  output  1  registered chip stream to the LED driver.
REQ-014 tx_busy  output  1  high in every state except IDLE.
REQ-015 tx_done  output  1  one-cycle pulse on normal frame completion.
REQ-016 tx_err  output  1  sticky odd-bit-count error; cleared by next accepted tx_go.

Function
REQ-017 States: IDLE, PREAMBLE, START, DATA, DRAIN, STOP; one-hot or binary at implementer's choice.
REQ-018 IDLE: fir_tx_o=0, next_data_fir=0; tx_go -> PREAMBLE next cycle, chip counter=0, ppm_restart pulses that same cycle.
REQ-019 tx_go while tx_busy is ignored.
REQ-020 fir_tx_o updates only on fir_tx8_enable cycles; holds value otherwise.
REQ-021 PREAMBLE: emit 16-bit pattern 1000_0000_1010_1000 MSB first, PREAMBLE_REPS times, then -> START.
REQ-022 START: emit 32-bit 0000_1100_0000_1100_0110_0000_0110_0000 MSB first, then -> DATA.
REQ-023 DATA: next_data_fir = fir_tx4_enable (combinational AND with state, same cycle); fir_tx_o takes ppm_i on each chip strobe.
REQ-024 DATA: bit parity toggles per next_data_fir; next_data_fir with data_last=1 -> DRAIN; tx_err set if that was an odd-numbered bit (1st, 3rd, ...).
REQ-025 DRAIN: next_data_fir=0; fir_tx_o keeps taking ppm_i for DRAIN_CHIPS chip strobes, then -> STOP.
REQ-026 STOP: emit 32-bit 0000_1100_0000_1100_0000_0110_0000_0110 MSB first; after last chip -> IDLE, tx_done pulses on the transition cycle, fir_tx_o=0 on the next chip strobe.
REQ-027 Chip counter 5 bits, cleared on every state change; wraps 15->0 in PREAMBLE incrementing repetition counter.
REQ-028 tx_abort in any non-IDLE state: -> IDLE next cycle, fir_tx_o=0 immediately, ppm_restart pulses, no tx_done; in IDLE no effect.
REQ-029 tx_abort and tx_go same cycle: abort wins, go ignored.
REQ-030 data_last high outside DATA is ignored.

Reset
REQ-031 wb_rst_i: state=IDLE, all counters 0, fir_tx_o=0, ppm_restart=0, next_data_fir=0, tx_busy=0, tx_done=0, tx_err=0.
REQ-032 Reset mid-frame takes effect asynchronously; no tx_done is generated.

Verification
REQ-033 Reset, tx_go, PREAMBLE_REPS=16 -> 256 preamble chips of the REQ-021 pattern, then 32 start-flag chips exactly; ppm_restart one pulse.
REQ-034 8-bit frame, encoder attached, bytes 0x1B -> 4 data symbols match 4PPM, DRAIN 8 chips, stop flag, tx_done once, tx_err=0; total chips 256+32+16+8+32=344.
REQ-035 data_last on 3rd bit -> tx_err=1 after frame, frame still completes; next tx_go clears tx_err.
REQ-036 tx_abort during 5th start-flag chip -> fir_tx_o=0 next cycle, tx_busy=0, ppm_restart pulse, no tx_done.
REQ-037 tx_go repeated during DATA and tx_go+tx_abort together in PREAMBLE -> first ignored, second returns to IDLE.
REQ-038 wb_rst_i asserted mid-DATA -> all outputs 0 asynchronously; subsequent tx_go starts a clean preamble.
